// File: rtl/round_ctrl.sv
// Round sequencer for the number-guessing game: target generation, enter-edge
// detection, comparator handshake, attempt counting and inactivity timeout.
module round_ctrl #(
    parameter int unsigned MAX_TRIES   = 8,
    parameter int unsigned TIMEOUT_CYC = 250000000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enter,
    input  logic [7:0] i_guess,
    output logic [7:0] o_target,
    output logic [7:0] o_cmp_guess,
    output logic       o_cmp_go,
    input  logic       i_cmp_valid,
    input  logic       i_under,
    input  logic       i_over,
    input  logic       i_equal,
    output logic       o_under,
    output logic       o_over,
    output logic       o_equal,
    output logic       o_update_leds,
    output logic [3:0] o_tries,
    output logic       o_win,
    output logic       o_lose
);
    localparam int unsigned     TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      TRY_LIMIT = 4'(MAX_TRIES);
    localparam logic [7:0]      SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_GUESS = 3'd1,
        COMPARE    = 3'd2,
        RESULT     = 3'd3,
        WIN        = 3'd4,
        LOSE       = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_enter_q;
    logic [7:0]      r_lfsr;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_target;
    logic [7:0]      r_cmp_guess;
    logic            r_cmp_go;
    logic            r_under;
    logic            r_over;
    logic            r_equal;
    logic            r_update_leds;
    logic [3:0]      r_tries;
    logic            r_win;
    logic            r_lose;

    logic            w_edge;
    logic            w_timeout;
    logic            w_no_flag;
    logic            w_lfsr_fb;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic [7:0]      w_target_nxt;
    logic [7:0]      w_cmp_guess_nxt;
    logic            w_cmp_go_nxt;
    logic            w_under_nxt;
    logic            w_over_nxt;
    logic            w_equal_nxt;
    logic            w_update_leds_nxt;
    logic [3:0]      w_tries_nxt;
    logic            w_win_nxt;
    logic            w_lose_nxt;

    assign w_edge    = i_enter & ~r_enter_q;
    assign w_timeout = (r_to_cnt == TO_LAST);
    assign w_no_flag = ~(i_under | i_over | i_equal);
    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an edge in WAIT_GUESS takes priority over the timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (w_edge) w_state_nxt = WAIT_GUESS;
            WAIT_GUESS: begin
                if (w_edge)         w_state_nxt = COMPARE;
                else if (w_timeout) w_state_nxt = LOSE;
            end
            COMPARE:    if (i_cmp_valid) w_state_nxt = RESULT;
            RESULT: begin
                if (r_equal)                  w_state_nxt = WIN;
                else if (r_tries == TRY_LIMIT) w_state_nxt = LOSE;
                else                          w_state_nxt = WAIT_GUESS;
            end
            WIN, LOSE:  if (w_edge) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values, registered below
    always_comb begin
        w_to_cnt_nxt      = r_to_cnt;
        w_target_nxt      = r_target;
        w_cmp_guess_nxt   = r_cmp_guess;
        w_cmp_go_nxt      = 1'b0;
        w_under_nxt       = r_under;
        w_over_nxt        = r_over;
        w_equal_nxt       = r_equal;
        w_update_leds_nxt = 1'b0;
        w_tries_nxt       = r_tries;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_target_nxt = r_lfsr;
                    w_tries_nxt  = 4'd0;
                    w_under_nxt  = 1'b0;
                    w_over_nxt   = 1'b0;
                    w_equal_nxt  = 1'b0;
                    w_to_cnt_nxt = '0;
                end
            end
            WAIT_GUESS: begin
                if (w_edge) begin
                    w_cmp_guess_nxt = i_guess;
                    w_cmp_go_nxt    = 1'b1;
                    w_to_cnt_nxt    = '0;
                end else if (w_timeout) begin
                    w_update_leds_nxt = 1'b1;
                    w_to_cnt_nxt      = '0;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            COMPARE: begin
                if (i_cmp_valid) begin
                    w_equal_nxt       = i_equal;
                    w_over_nxt        = ~i_equal & i_over;
                    w_under_nxt       = ~i_equal & ~i_over & (i_under | w_no_flag);
                    w_tries_nxt       = (r_tries == 4'd15) ? r_tries : r_tries + 4'd1;
                    w_update_leds_nxt = 1'b1;
                end
            end
            RESULT: begin
                w_to_cnt_nxt = '0;
            end
            WIN, LOSE: begin
                if (w_edge) begin
                    w_under_nxt       = 1'b0;
                    w_over_nxt        = 1'b0;
                    w_equal_nxt       = 1'b0;
                    w_update_leds_nxt = 1'b1;
                end
            end
            default: begin
                w_to_cnt_nxt = '0;
            end
        endcase
        w_win_nxt  = (w_state_nxt == WIN);
        w_lose_nxt = (w_state_nxt == LOSE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enter_q     <= 1'b0;
            r_lfsr        <= SEED;
            r_to_cnt      <= '0;
            r_target      <= 8'd0;
            r_cmp_guess   <= 8'd0;
            r_cmp_go      <= 1'b0;
            r_under       <= 1'b0;
            r_over        <= 1'b0;
            r_equal       <= 1'b0;
            r_update_leds <= 1'b0;
            r_tries       <= 4'd0;
            r_win         <= 1'b0;
            r_lose        <= 1'b0;
        end else begin
            r_enter_q     <= i_enter;
            r_lfsr        <= {r_lfsr[6:0], w_lfsr_fb};
            r_to_cnt      <= w_to_cnt_nxt;
            r_target      <= w_target_nxt;
            r_cmp_guess   <= w_cmp_guess_nxt;
            r_cmp_go      <= w_cmp_go_nxt;
            r_under       <= w_under_nxt;
            r_over        <= w_over_nxt;
            r_equal       <= w_equal_nxt;
            r_update_leds <= w_update_leds_nxt;
            r_tries       <= w_tries_nxt;
            r_win         <= w_win_nxt;
            r_lose        <= w_lose_nxt;
        end
    end

    assign o_target      = r_target;
    assign o_cmp_guess   = r_cmp_guess;
    assign o_cmp_go      = r_cmp_go;
    assign o_under       = r_under;
    assign o_over        = r_over;
    assign o_equal       = r_equal;
    assign o_update_leds = r_update_leds;
    assign o_tries       = r_tries;
    assign o_win         = r_win;
    assign o_lose        = r_lose;

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: stimulus pushes expected comparator requests
// and LED updates, a negedge monitor pops and compares them.
module tb_round_ctrl;
    localparam int unsigned MAX_TRIES   = 3;
    localparam int unsigned TIMEOUT_CYC = 20;
    localparam logic [7:0]  SEED        = 8'hA5;

    typedef struct packed {
        logic [7:0] guess;
        logic [7:0] target;
    } go_t;

    typedef struct packed {
        logic       u;
        logic       o;
        logic       e;
        logic [3:0] tries;
        logic       win;
        logic       lose;
    } upd_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_enter = 1'b0;
    logic [7:0] i_guess = 8'd0;
    logic       i_cmp_valid = 1'b0;
    logic       i_under = 1'b0;
    logic       i_over = 1'b0;
    logic       i_equal = 1'b0;

    logic [7:0] o_target, o_cmp_guess;
    logic       o_cmp_go, o_under, o_over, o_equal, o_update_leds, o_win, o_lose;
    logic [3:0] o_tries;

    logic [7:0] d0_target, d0_cmp_guess;
    logic       d0_cmp_go, d0_under, d0_over, d0_equal, d0_update_leds, d0_win, d0_lose;
    logic [3:0] d0_tries;

    round_ctrl #(.MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .i_enter(i_enter), .i_guess(i_guess),
        .o_target(o_target), .o_cmp_guess(o_cmp_guess), .o_cmp_go(o_cmp_go),
        .i_cmp_valid(i_cmp_valid), .i_under(i_under), .i_over(i_over), .i_equal(i_equal),
        .o_under(o_under), .o_over(o_over), .o_equal(o_equal),
        .o_update_leds(o_update_leds), .o_tries(o_tries), .o_win(o_win), .o_lose(o_lose)
    );

    round_ctrl #(.MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC), .LFSR_SEED(8'h00)) dut0 (
        .clk(clk), .reset(reset), .i_enter(i_enter), .i_guess(i_guess),
        .o_target(d0_target), .o_cmp_guess(d0_cmp_guess), .o_cmp_go(d0_cmp_go),
        .i_cmp_valid(i_cmp_valid), .i_under(i_under), .i_over(i_over), .i_equal(i_equal),
        .o_under(d0_under), .o_over(d0_over), .o_equal(d0_equal),
        .o_update_leds(d0_update_leds), .o_tries(d0_tries), .o_win(d0_win), .o_lose(d0_lose)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    go_t         go_q[$];
    upd_t        upd_q[$];

    // Game model
    int         phase = 0;   // 0 idle, 1 playing, 2 round over
    logic [7:0] m_target = 8'd0;
    int         m_tries = 0;
    logic       m_u = 1'b0, m_o = 1'b0, m_e = 1'b0, m_win = 1'b0, m_lose = 1'b0;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [7:0] lfsr_at(input int unsigned n);
        logic [7:0] v;
        v = SEED;
        for (int unsigned i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    go_t  mon_go;
    upd_t mon_upd;
    logic prev_upd = 1'b0;
    always @(negedge clk) begin
        if (o_cmp_go) begin
            if (go_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL go_unexpected got=1 exp=0 (t=%0t)", $time);
            end else begin
                mon_go = go_q.pop_front();
                chk("go_guess_sb", 32'(o_cmp_guess), 32'(mon_go.guess));
                chk("go_target_sb", 32'(o_target), 32'(mon_go.target));
            end
        end
        if (o_update_leds) begin
            chk("upd_consecutive", 32'(prev_upd), 32'(0));
            if (upd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL upd_unexpected got=1 exp=0 (t=%0t)", $time);
            end else begin
                mon_upd = upd_q.pop_front();
                chk("upd_payload",
                    32'({o_under, o_over, o_equal, o_tries, o_win, o_lose}), 32'(mon_upd));
            end
        end
        prev_upd = o_update_leds;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] g, input int h);
        i_guess = g;
        i_enter = 1'b1;
        tick(h);
        i_enter = 1'b0;
    endtask

    task automatic start_round(input int h);
        m_target = lfsr_at(cyc);
        m_tries = 0;
        m_u = 1'b0; m_o = 1'b0; m_e = 1'b0; m_win = 1'b0; m_lose = 1'b0;
        phase = 1;
        press(8'($urandom), h);
        chk("start_target", 32'(o_target), 32'(m_target));
        chk("start_tries", 32'(o_tries), 32'(0));
    endtask

    task automatic guess(input logic [7:0] g, input int h, input int d,
                         input logic [2:0] flags, input bit glitch);
        go_t  gexp;
        upd_t uexp;
        gexp.guess = g;
        gexp.target = m_target;
        go_q.push_back(gexp);
        press(g, h);
        if (h == 1) begin
            chk("go_timing", 32'(o_cmp_go), 32'(1));
            chk("go_guess", 32'(o_cmp_guess), 32'(g));
        end
        i_guess = 8'($urandom);
        if (glitch) begin
            tick(1); i_enter = 1'b1; tick(1); i_enter = 1'b0;
        end
        tick(d);
        m_tries = (m_tries < 15) ? m_tries + 1 : 15;
        m_e = flags[2];
        m_o = !flags[2] && flags[1];
        m_u = !m_e && !m_o;
        m_win = m_e;
        m_lose = !m_e && (m_tries == int'(MAX_TRIES));
        uexp.u = m_u; uexp.o = m_o; uexp.e = m_e;
        uexp.tries = 4'(m_tries); uexp.win = 1'b0; uexp.lose = 1'b0;
        upd_q.push_back(uexp);
        i_cmp_valid = 1'b1;
        {i_equal, i_over, i_under} = flags;
        tick(1);
        i_cmp_valid = 1'b0;
        {i_equal, i_over, i_under} = 3'($urandom);
        tick(1);
        chk("post_win", 32'(o_win), 32'(m_win));
        chk("post_lose", 32'(o_lose), 32'(m_lose));
        chk("post_tries", 32'(o_tries), 32'(m_tries));
        phase = (m_win || m_lose) ? 2 : 1;
    endtask

    task automatic end_round(input int h);
        upd_t uexp;
        uexp.u = 1'b0; uexp.o = 1'b0; uexp.e = 1'b0;
        uexp.tries = 4'(m_tries); uexp.win = 1'b0; uexp.lose = 1'b0;
        upd_q.push_back(uexp);
        m_u = 1'b0; m_o = 1'b0; m_e = 1'b0; m_win = 1'b0; m_lose = 1'b0;
        phase = 0;
        press(8'($urandom), h);
        chk("end_win", 32'(o_win), 32'(0));
        chk("end_lose", 32'(o_lose), 32'(0));
    endtask

    task automatic idle_timeout();
        upd_t uexp;
        uexp.u = m_u; uexp.o = m_o; uexp.e = m_e;
        uexp.tries = 4'(m_tries); uexp.win = 1'b0; uexp.lose = 1'b1;
        upd_q.push_back(uexp);
        tick(TIMEOUT_CYC + 4);
        m_lose = 1'b1;
        phase = 2;
        chk("timeout_lose", 32'(o_lose), 32'(1));
    endtask

    task automatic rand_flags(output logic [2:0] f);
        f = {($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
    endtask

    task automatic play_out();
        logic [2:0] f;
        while (phase == 1) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_timeout();
            end else begin
                tick(1 + int'($urandom_range(0, 4)));
                rand_flags(f);
                guess(8'($urandom), 1 + int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), f, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        logic [2:0] f;
        upd_t uexp;
        go_t  gexp;

        // Reset held two cycles
        tick(2);
        chk("rst_target", 32'(o_target), 32'(0));
        chk("rst_cmp", 32'({o_cmp_guess, o_cmp_go}), 32'(0));
        chk("rst_flags", 32'({o_under, o_over, o_equal, o_update_leds}), 32'(0));
        chk("rst_tries", 32'(o_tries), 32'(0));
        chk("rst_winlose", 32'({o_win, o_lose}), 32'(0));
        chk("rst_d0_target", 32'(d0_target), 32'(0));

        // Capture on the first cycle after reset, enter held for 10 cycles
        reset = 1'b0;
        start_round(10);
        chk("capture_a5", 32'(o_target), 32'(8'hA5));
        chk("capture_seed0", 32'(d0_target), 32'(8'h01));

        // Handshake with an under result 3 cycles after go, then a win
        tick(1);
        guess(8'h10, 1, 2, 3'b001, 1'b0);
        chk("under_flag", 32'(o_under), 32'(1));
        tick(1);
        guess(8'h77, 1, 0, 3'b110, 1'b0);
        chk("win_equal_only", 32'({o_under, o_over, o_equal}), 32'(3'b001));
        tick(1);
        end_round(2);

        // Loss by tries
        tick(2);
        start_round(1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            guess(8'($urandom), 1, 1, 3'b010, 1'b0);
        end
        chk("tries_loss", 32'({o_tries, o_lose}), 32'({4'd3, 1'b1}));
        tick(1);
        end_round(1);

        // Timeout lands exactly TIMEOUT_CYC cycles into WAIT_GUESS
        tick(1);
        start_round(1);
        uexp.u = 1'b0; uexp.o = 1'b0; uexp.e = 1'b0;
        uexp.tries = 4'd0; uexp.win = 1'b0; uexp.lose = 1'b1;
        upd_q.push_back(uexp);
        tick(TIMEOUT_CYC - 1);
        chk("timeout_early", 32'(o_lose), 32'(0));
        tick(1);
        chk("timeout_exact", 32'(o_lose), 32'(1));
        m_lose = 1'b1;
        phase = 2;
        tick(1);
        end_round(1);

        // Edge in the final timeout cycle beats the timeout
        tick(1);
        start_round(1);
        tick(TIMEOUT_CYC - 1);
        rand_flags(f);
        guess(8'hC3, 1, 1, f, 1'b0);
        play_out();
        tick(1);
        end_round(1);

        // Reset while waiting in COMPARE; late valid ignored
        tick(1);
        start_round(1);
        tick(1);
        gexp.guess = 8'h5A;
        gexp.target = m_target;
        go_q.push_back(gexp);
        press(8'h5A, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        phase = 0; m_tries = 0;
        m_u = 1'b0; m_o = 1'b0; m_e = 1'b0; m_win = 1'b0; m_lose = 1'b0;
        tick(1);
        i_cmp_valid = 1'b1; i_under = 1'b1;
        tick(1);
        i_cmp_valid = 1'b0; i_under = 1'b0;
        tick(3);
        chk("midrst_tries", 32'(o_tries), 32'(0));
        chk("midrst_target", 32'(o_target), 32'(0));
        chk("midrst_flags", 32'({o_under, o_over, o_equal, o_win, o_lose}), 32'(0));

        // Randomised games
        for (int gi = 0; gi < 30; gi++) begin
            tick(1 + int'($urandom_range(0, 2)));
            start_round(1 + int'($urandom_range(0, 2)));
            play_out();
            tick(1 + int'($urandom_range(0, 2)));
            end_round(1 + int'($urandom_range(0, 2)));
        end

        tick(5);
        chk("go_q_drained", 32'(go_q.size()), 32'(0));
        chk("upd_q_drained", 32'(upd_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
- Round sequencer for the number-guessing game.
- Generates a pseudo-random 8-bit target and edge-detects the enter key.
- Hands each guess to the external comparator datapath over a go/valid handshake, then counts attempts against a limit.
- Drives the LED update strobe and enforces an inactivity timeout. Sits between the KEY/SW inputs and the comparator / led_ctrl instances.

Parameters:
- MAX_TRIES, 8, attempts allowed per round (1..15).
- TIMEOUT_CYC, 250000000, idle cycles in WAIT_GUESS before forced loss (5 s at 50 MHz).
- LFSR_SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- i_enter  in  1  enter key, active-high level (already inverted), not debounced.
- i_guess  in  8  guess value from switches.
- o_target  out  8  current round target to comparator.
- o_cmp_guess  out  8  guess latched at enter edge, to comparator.
- o_cmp_go  out  1  one-cycle request to comparator.
- i_cmp_valid  in  1  comparator result valid (single-cycle pulse).
- i_under  in  1  guess < target (sampled when i_cmp_valid).
- i_over  in  1  guess > target (sampled when i_cmp_valid).
- i_equal  in  1  guess == target (sampled when i_cmp_valid).
- o_under  out  1  registered last result.
- o_over  out  1  registered last result.
- o_equal  out  1  registered last result.
- o_update_leds  out  1  one-cycle strobe when the o_* results change.
- o_tries  out  4  attempts used this round.
- o_win  out  1  high in WIN state.
- o_lose  out  1  high in LOSE state.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state=IDLE; LFSR=LFSR_SEED (or 8'h01 if the seed is 0).
  - o_target=0, o_cmp_guess=0, o_cmp_go=0.
  - o_under/o_over/o_equal=0, o_update_leds=0, o_tries=0.
  - o_win=0, o_lose=0; timeout counter=0; enter_q=0.
- Enter edge: enter_q <= i_enter each cycle; edge = i_enter & ~enter_q.
  - Holding enter produces exactly one edge.
  - Edges in COMPARE or RESULT are ignored (not queued).
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle in every state and never reaches 0.
- IDLE: on edge, o_target <= current LFSR value, o_tries <= 0, o_under/o_over/o_equal <= 0, timeout counter <= 0; go to WAIT_GUESS.
- WAIT_GUESS:
  - The timeout counter increments each cycle.
  - On edge: o_cmp_guess <= i_guess, counter <= 0, go to COMPARE. o_cmp_go is high for exactly the first COMPARE cycle (1 cycle after the edge sample).
  - If the counter reaches TIMEOUT_CYC-1 without an edge, go to LOSE. An edge in that same cycle wins over the timeout.
- COMPARE:
  - Wait for i_cmp_valid; no timeout, and o_cmp_go is not re-issued.
  - On valid, latch results with priority equal > over > under; exactly one o_* flag is set. A valid with no flags set latches o_under=1.
  - Go to RESULT.
- RESULT (1 cycle):
  - o_update_leds=1 and o_tries increments (saturates at 15).
  - Next state: if o_equal, WIN; else if the new o_tries == MAX_TRIES, LOSE; else WAIT_GUESS with counter=0.
- WIN / LOSE:
  - o_win / o_lose is high; o_under/o_over/o_equal hold their last values.
  - On edge, go to IDLE and pulse o_update_leds with all o_* results cleared. That same edge does not start a new round; a second edge is required.
- Timeout entry into LOSE also pulses o_update_leds for 1 cycle, with results unchanged.
- Reset asserted in any state, including mid-COMPARE: next cycle all reset values apply. A late i_cmp_valid is then ignored because the state is not COMPARE.
- o_update_leds never pulses on two consecutive cycles.

Test Plan:
- Reset, then LFSR_SEED=8'hA5: hold reset 2 cycles -> all outputs 0, state IDLE; with seed 0 the LFSR reads 8'h01 on the first cycle after reset.
- Target capture: enter edge in IDLE at a known LFSR value (e.g. 8'h3C) -> o_target=8'h3C, o_tries=0; holding enter 100 cycles causes no second capture.
- Guess handshake: i_guess=8'h10, enter edge -> o_cmp_go high exactly 1 cycle later with o_cmp_guess=8'h10. Return valid+i_under 3 cycles later -> o_under=1, o_update_leds 1-cycle pulse, o_tries=1.
- Win: valid with i_equal=1 and i_over=1 -> o_equal=1 only, o_win=1; enter edge -> IDLE with results cleared and one o_update_leds pulse.
- Loss by tries, MAX_TRIES=3: three over results -> o_tries=3, o_lose=1. Loss by timeout, TIMEOUT_CYC=20: no enter -> o_lose=1 after 20 cycles in WAIT_GUESS.
- Reset mid-COMPARE: assert reset while waiting, then pulse i_cmp_valid after release -> state IDLE, no o_update_leds pulse, o_tries=0.
